// File: rtl/urf_cmd_sequencer_if.sv
// Command/response handshake bundle between a requester and urf_cmd_sequencer.
// master = requester side, slave = sequencer side.
interface urf_cmd_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [31:0]           cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_write, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_write, rsp_data, rsp_err
    );
endinterface

// File: rtl/urf_cmd_sequencer.sv
// FIFO-buffered command front-end for universal_reg_array: one command in flight, one response each.
// Optional macro URF_SEQ_RANGE_CHECK_EN: commands with addr >= DEPTH are answered with rsp_err instead of issued.
module urf_cmd_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    urf_cmd_sequencer_if.slave    bus,
    output logic [31:0]           reg_read_addr_o,
    output logic [31:0]           reg_write_addr_o,
    output logic [DATA_WIDTH-1:0] reg_write_data_o,
    output logic                  reg_write_en_o,
    output logic                  reg_read_en_o,
    input  logic [DATA_WIDTH-1:0] reg_read_data_i,
    input  logic                  reg_busy_i
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LAT_W = $clog2(RD_LAT + 1);
`ifdef URF_SEQ_RANGE_CHECK_EN
    localparam logic RANGE_EN = 1'b1;
`else
    localparam logic RANGE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    typedef struct packed {
        logic                  write;
        logic [31:0]           addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    cmd_t                  fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    state_e                state_q, state_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  cur_write_q, cur_write_d, cur_err_q, cur_err_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [31:0]           rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic                  push_c, pop_c, head_oor_c;
    cmd_t                  head_c, cmd_in_c;

    assign push_c     = bus.cmd_valid & cmd_ready_q;
    assign head_c     = fifo_q[rd_ptr_q];
    assign head_oor_c = RANGE_EN & (head_c.addr >= 32'(DEPTH));
    assign cmd_in_c   = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};

    // Command storage; contents are meaningless outside the occupied window, so no reset.
    always_ff @(posedge clk) begin
        if (push_c) fifo_q[wr_ptr_q] <= cmd_in_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            lat_q       <= '0;
            cur_write_q <= 1'b0;
            cur_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            cur_write_q <= cur_write_d;
            cur_err_q   <= cur_err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
        end
    end

    // Next state plus next values of every registered output; enables are armed on entry to ISSUE.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        cur_write_d = cur_write_q;
        cur_err_d   = cur_err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        pop_c       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if ((cnt_q != '0) && !reg_busy_i) begin
                    pop_c       = 1'b1;
                    state_d     = ISSUE;
                    cur_write_d = head_c.write;
                    cur_err_d   = head_oor_c;
                    if (!head_oor_c) begin
                        if (head_c.write) begin
                            wr_addr_d = head_c.addr;
                            wr_data_d = head_c.wdata;
                            wr_en_d   = 1'b1;
                        end else begin
                            rd_addr_d = head_c.addr;
                            rd_en_d   = 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                if (cur_write_q || cur_err_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = cur_write_q;
                    rsp_err_d   = cur_err_q;
                    rsp_data_d  = '0;
                end else begin
                    state_d = WAIT;
                    lat_d   = LAT_W'(1);
                end
            end
            WAIT: begin
                if (lat_q == LAT_W'(RD_LAT)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = reg_read_data_i;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push_c ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        unique case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        cmd_ready_d = (cnt_d != CNT_W'(FIFO_DEPTH));
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_write    = rsp_write_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_err      = rsp_err_q;
    assign reg_read_addr_o  = rd_addr_q;
    assign reg_write_addr_o = wr_addr_q;
    assign reg_write_data_o = wr_data_q;
    assign reg_write_en_o   = wr_en_q;
    assign reg_read_en_o    = rd_en_q;
endmodule
